// File: rtl/up_down_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// up_down_ctrl_pkg
// Shared definitions for the up/down count controller:
//   state_e  - controller FSM states (IDLE, RUN, DONE)
//   DIR_UP   - step direction value for counting up   (1)
//   DIR_DOWN - step direction value for counting down (0)
// ---------------------------------------------------------------------------
package up_down_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : up_down_ctrl_pkg

// File: rtl/up_down_counter_core.sv
// ---------------------------------------------------------------------------
// up_down_counter_core
// Enable-gated WIDTH-bit up/down counter that wraps modulo 2^WIDTH.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset, clears count to 0
//   en         in   step enable for this cycle
//   up         in   step direction (DIR_UP / DIR_DOWN)
//   count      out  registered counter value
//   count_next out  value count takes if a step is enabled this cycle
// ---------------------------------------------------------------------------
module up_down_counter_core
    import up_down_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    logic [WIDTH-1:0] count_q;

    // Wrap-around falls out of the fixed-width arithmetic.
    assign count_next = (up == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    assign count      = count_q;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_next;
        end
    end

endmodule : up_down_counter_core

// File: rtl/up_down_count_ctrl.sv
// ---------------------------------------------------------------------------
// up_down_count_ctrl
// Accepts a target count, then steps an up/down counter one per cycle until
// the target is reached, pulsing done for one cycle. A running command can be
// cancelled with abort (no done pulse).
//
// Configuration macro: UP_DOWN_CTRL_SHORTEST_EN
//   defined   - direction of shortest modular distance, ties go up
//   undefined - up if target > count, down if target < count (never wraps)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   cmd_valid  in   target command valid
//   cmd_ready  out  high in IDLE, command can be accepted
//   cmd_target in   requested final count
//   abort      in   cancel the running command (only honoured in RUN)
//   count      out  current counter value
//   up_down    out  current step direction, 1 = up, 0 = down
//   busy       out  high in RUN
//   done       out  one-cycle completion pulse (DONE state)
// ---------------------------------------------------------------------------
module up_down_count_ctrl
    import up_down_ctrl_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_target,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [WIDTH-1:0] target_q;
    logic             up_down_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] count_d;
    logic             step_en;
    logic             cmd_dir;

    // Abort wins over stepping, so the counter holds on the abort cycle.
    assign step_en = (state_q == RUN) && !abort;

    up_down_counter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .en        (step_en),
        .up        (up_down_q),
        .count     (count),
        .count_next(count_d)
    );

`ifdef UP_DOWN_CTRL_SHORTEST_EN
    logic [WIDTH-1:0] dist_up;
    logic [WIDTH-1:0] dist_down;

    // Modular distances in each direction; equal distances resolve upward.
    // NOTE: every signal assigned in always_comb gets a value on every path
    // (default first), otherwise synthesis infers a latch.
    always_comb begin
        cmd_dir   = DIR_UP;
        dist_up   = cmd_target - count;
        dist_down = count - cmd_target;
        if (dist_down < dist_up) begin
            cmd_dir = DIR_DOWN;
        end
    end
`else
    // Plain magnitude compare: the path never crosses the wrap point.
    always_comb begin
        cmd_dir = DIR_DOWN;
        if (cmd_target > count) begin
            cmd_dir = DIR_UP;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            target_q  <= '0;
            up_down_q <= DIR_UP;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        target_q <= cmd_target;
                        if (cmd_target == count) begin
                            // Already there: complete without stepping, and
                            // keep the previous direction since none applies.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= RUN;
                            busy_q    <= 1'b1;
                            up_down_q <= cmd_dir;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (count_d == target_q) begin
                        // This edge performs the final step.
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign up_down   = up_down_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule : up_down_count_ctrl

// File: tb/tb_up_down_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_up_down_count_ctrl
// Scoreboard bench for up_down_count_ctrl (WIDTH = 3). The reference model
// plans each command as a list of counts still to visit; expected outputs are
// queued by the stimulus side and compared by a monitor on the falling edge.
// ---------------------------------------------------------------------------
module tb_up_down_count_ctrl;

    localparam int W = 3;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_target;
    logic         abort;
    logic [W-1:0] count;
    logic         up_down;
    logic         busy;
    logic         done;

    up_down_count_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_target(cmd_target),
        .abort     (abort),
        .count     (count),
        .up_down   (up_down),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] count;
        logic         up_down;
        logic         busy;
        logic         done;
        logic         ready;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: current count, chosen direction, the counts still to
    // visit for the running command, and a pending completion pulse.
    int   m_count;
    logic m_dir;
    int   m_plan[$];
    bit   m_done;

    function automatic obs_t model_obs();
        obs_t o;
        o.count   = W'(m_count);
        o.up_down = m_dir;
        o.busy    = (m_plan.size() > 0);
        o.done    = m_done;
        o.ready   = (m_plan.size() == 0) && !m_done;
        return o;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_dir   = 1'b1;
        m_plan.delete();
        m_done  = 1'b0;
    endtask

    task automatic model_edge(input logic v, input int t, input logic a);
        int  du;
        int  dd;
        int  d;
        bit  up;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_plan.size() > 0) begin
            if (a) begin
                m_plan.delete();
            end else begin
                m_count = m_plan.pop_front();
                if (m_plan.size() == 0) m_done = 1'b1;
            end
        end else if (v) begin
            if (t == m_count) begin
                m_done = 1'b1;
            end else begin
                du = (t - m_count + M) % M;
                dd = (m_count - t + M) % M;
`ifdef UP_DOWN_CTRL_SHORTEST_EN
                up = (du <= dd);
`else
                up = (t > m_count);
`endif
                d     = up ? du : dd;
                m_dir = up;
                for (int i = 1; i <= d; i++) begin
                    m_plan.push_back((m_count + (up ? i : M - i)) % M);
                end
            end
        end
    endtask

    // One clock of stimulus; inputs change 2 time units after the edge.
    task automatic drive(input logic v, input int t, input logic a);
        cmd_valid  = v;
        cmd_target = W'(t);
        abort      = a;
        @(posedge clk);
        model_edge(v, t, a);
        sb.push_back(model_obs());
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    task automatic go_to(input int t);
        drive(1'b1, t, 1'b0);
        idle(M + 1);
    endtask

    // Reset asserted between edges; the pending expectation for this cycle is
    // replaced because the outputs change before the monitor samples them.
    task automatic do_reset(input int cycles);
        obs_t dummy;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        rst       = 1'b0;
        model_reset();
        if (sb.size() > 0) dummy = sb.pop_back();
        sb.push_back(model_obs());
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            sb.push_back(model_obs());
            #2;
        end
        rst = 1'b1;
    endtask

    // Monitor: compare one queued expectation per falling edge.
    initial begin : monitor
        obs_t e;
        obs_t got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                got = '{count, up_down, busy, done, cmd_ready};
                n_vec++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL vec%0d @%0t: got count=%0d up_down=%0b busy=%0b done=%0b ready=%0b, expected count=%0d up_down=%0b busy=%0b done=%0b ready=%0b",
                             n_vec, $time, got.count, got.up_down, got.busy, got.done, got.ready,
                             e.count, e.up_down, e.busy, e.done, e.ready);
                end
            end
        end
    end

    initial begin : stimulus
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        abort      = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        do_reset(2);

        // 0 -> 5: up, five steps, one-cycle done pulse.
        go_to(5);
        // 5 -> 1, then 1 -> 6 (down by three with shortest path, else up by five).
        go_to(1);
        go_to(6);
        // Same target twice: second command completes on the accepting edge.
        go_to(3);
        go_to(3);

        // 0 -> 7 with cmd_valid held during RUN; abort while count is 2.
        go_to(0);
        drive(1'b1, 7, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (m_count == 2 && m_plan.size() > 0) begin
                drive(1'b1, $urandom_range(0, M - 1), 1'b1);
                break;
            end
            drive(1'b1, $urandom_range(0, M - 1), 1'b0);
        end
        idle(3);
        // Abort outside RUN has no effect.
        drive(1'b0, 0, 1'b1);

        // 0 -> 4: equal distances, direction up.
        go_to(0);
        go_to(4);

        // Reset mid-RUN at count 4 (2 -> 6 goes up in either build).
        go_to(2);
        drive(1'b1, 6, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (m_count == 4 && m_plan.size() > 0) begin
                do_reset(2);
                break;
            end
            drive(1'b0, 0, 1'b0);
        end
        idle(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, M - 1),
                  1'($urandom_range(0, 11) == 0));
        end
        idle(M + 1);

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d unchecked expectations, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_up_down_count_ctrl

// File: doc/up_down_count_ctrl.md
UP_DOWN_COUNT_CTRL -- requirements
Module: up_down_count_ctrl

Interface
REQ-001 SHALL provide parameter: WIDTH, 3, counter/target width in bits.
REQ-002 SHALL provide port: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL provide port: rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide port: cmd_valid  in  1  target command valid.
REQ-005 SHALL provide port: cmd_ready  out  1  controller can accept command.
REQ-006 SHALL provide port: cmd_target  in  WIDTH  requested final count.
REQ-007 SHALL provide port: abort  in  1  cancel the running command.
REQ-008 SHALL provide port: count  out  WIDTH  current counter value.
REQ-009 SHALL provide port: up_down  out  1  current step direction: 1 = up, 0 = down.
REQ-010 SHALL provide port: busy  out  1  high in RUN.
REQ-011 SHALL provide port: done  out  1  one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; cmd_ready = 1 only in IDLE; done = 1 only in DONE.
REQ-013 SHALL accept a command on a rising edge where cmd_valid and cmd_ready are both high, latching cmd_target and the direction.
REQ-014 SHALL go IDLE->DONE on the accepting edge when cmd_target == count, leaving count unchanged.
REQ-015 SHALL go IDLE->RUN on the accepting edge otherwise; count is unchanged on that edge.
REQ-016 SHALL, in RUN, step count by exactly 1 per cycle in the latched direction, wrapping modulo 2^WIDTH (max+1 -> 0, 0-1 -> max).
REQ-017 SHALL enter DONE on the edge where count becomes the target: accept at edge k with distance d >= 1 gives the last step and DONE at edge k+d.
REQ-018 SHALL return DONE->IDLE unconditionally on the next edge.
REQ-019 SHALL give abort priority in RUN: the step in that cycle is suppressed, count holds, the state goes to IDLE, and done is never asserted.
REQ-020 SHALL ignore abort in IDLE and DONE.
REQ-021 SHALL ignore cmd_valid outside IDLE, with no queuing.
REQ-022 SHALL hold up_down at its latched value outside RUN.
REQ-023 SHALL drive all outputs from registers or state decode only, with no combinational path from inputs.

Reset
REQ-024 SHALL, while rst = 0, immediately force state = IDLE, count = 0, up_down = 1, latched target = 0, busy = 0 and done = 0; cmd_ready = 1 follows from IDLE.
REQ-025 SHALL abandon any command in progress on reset with no done pulse, and resume on the first rising edge after rst rises.

Configuration
REQ-026 SHALL use the macro UP_DOWN_CTRL_SHORTEST_EN.
REQ-027 SHALL, with the macro defined, choose the direction of shortest modular distance; ties go up.
REQ-028 SHALL, with the macro undefined, choose up if target > count and down if target < count, never wrapping during a command.

Structure
REQ-029 SHALL place the state enum (IDLE/RUN/DONE) and the direction constants DIR_UP = 1 and DIR_DOWN = 0 in shared package up_down_ctrl_pkg.
REQ-030 SHALL instantiate one sub-module, up_down_counter_core: an enable-gated WIDTH-bit up/down counter with asynchronous active-low reset to 0; the FSM drives its enable and direction.

Verification (WIDTH = 3)
REQ-031 SHALL check: rst = 0 mid-RUN at count 4 -> immediately count = 0, busy = 0, done = 0, cmd_ready = 1.
REQ-032 SHALL check: count 0, target 5, macro off -> up_down = 1, count 1..5 on edges k+1..k+5, done high for exactly the cycle after edge k+5.
REQ-033 SHALL check: count 1, target 6, macro on -> up_down = 0, count 0, 7, 6, done after the third step; with the macro off -> 5 up steps.
REQ-034 SHALL check: count 3, target 3 -> DONE on the accepting edge, done for 1 cycle, count stays 3, busy never high.
REQ-035 SHALL check: count 0, target 7 (macro off), abort while count = 2 -> count stays 2, IDLE next, no done; cmd_valid held during RUN is ignored.
REQ-036 SHALL check: count 0, target 4, macro on (tie) -> direction up, four steps.
